// File: rtl/ysyx_23060203_scoreboard_pkg.sv
// Shared definitions for the register-hazard scoreboard.
//   sb_entry_t        : one in-flight instruction record {valid, rd}
//   SB_DEPTH_DEFAULT  : default number of in-flight instructions tracked
package ysyx_23060203_scoreboard_pkg;

   localparam int unsigned SB_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
   } sb_entry_t;

endpackage

// File: rtl/ysyx_23060203_sb_match.sv
// DEPTH-way destination comparator: flags when any valid, non-excluded entry
// writes the queried source register. Register 0 never matches.
// Ports:
//   entries : queue contents (packed, one sb_entry_t per slot)
//   exclude : per-slot mask of entries to ignore this cycle
//   rs      : source register being checked
//   busy    : a pending write to rs exists
module ysyx_23060203_sb_match
   import ysyx_23060203_scoreboard_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
   input  sb_entry_t [DEPTH-1:0] entries,
   input  logic      [DEPTH-1:0] exclude,
   input  logic      [4:0]       rs,
   output logic                  busy
);

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries[i].valid && !exclude[i] && (entries[i].rd == rs)) begin
            busy = 1'b1;
         end
      end
      // rd=0 entries (stores, branches) are recorded but never a hazard.
      busy = busy & (rs != 5'd0);
   end

endmodule

// File: rtl/ysyx_23060203_scoreboard.sv
// In-order register-hazard scoreboard between decode and writeback.
// Every accepted issue pushes its rd (rd=0 included) into an age-ordered
// circular queue; every writeback retires the head. Decode's rs1/rs2 are
// compared against all in-flight rds to raise busy/hazard.
// Optional feature macro: YSYX_23060203_SB_WB_BYPASS_EN -- when defined, the
// head entry being correctly retired this cycle no longer counts as busy.
// Ports:
//   clock, reset          : core clock, async active-high reset
//   issue_fire, issue_rd  : decode->EXU handshake and its destination
//   issue_ready           : queue can take an issue this cycle
//   q_rs1, q_rs2          : decode's current sources
//   rs1_busy, rs2_busy    : pending write to the matching source
//   hazard                : rs1_busy | rs2_busy
//   wb_valid, wb_rd       : oldest instruction retires, with its rd
//   count, empty, full    : occupancy
//   err                   : sticky protocol error
module ysyx_23060203_scoreboard
   import ysyx_23060203_scoreboard_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           issue_fire,
   input  logic [4:0]     issue_rd,
   output logic           issue_ready,
   input  logic [4:0]     q_rs1,
   input  logic [4:0]     q_rs2,
   output logic           rs1_busy,
   output logic           rs2_busy,
   output logic           hazard,
   input  logic           wb_valid,
   input  logic [4:0]     wb_rd,
   output logic [PTR_W:0] count,
   output logic           empty,
   output logic           full,
   output logic           err
);

   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

   sb_entry_t [DEPTH-1:0] entries_q, entries_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [PTR_W:0]        count_q, count_d;
   logic                  err_q, err_d;
   logic                  push, pop, head_match;
   logic [DEPTH-1:0]      wb_exclude;

   assign empty       = (count_q == '0);
   assign full        = (count_q == FULL_COUNT);
   // A pop frees a slot in the same cycle, so a full queue still accepts.
   assign issue_ready = ~full | wb_valid;
   assign count       = count_q;
   assign err         = err_q;

   assign push       = issue_fire & issue_ready;
   assign pop        = wb_valid & ~empty;
   assign head_match = (entries_q[head_q].rd == wb_rd);

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      err_d     = err_q | (issue_fire & ~issue_ready) | (wb_valid & empty)
                        | (pop & ~head_match);
      // Pop before push: when full, head==tail and the push reuses the slot.
      if (pop) begin
         entries_d[head_q].valid = 1'b0;
         head_d = head_q + PTR_ONE;
      end
      if (push) begin
         entries_d[tail_q] = '{valid: 1'b1, rd: issue_rd};
         tail_d = tail_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

`ifdef YSYX_23060203_SB_WB_BYPASS_EN
   // The retiring head is readable through the regfile write-through path.
   always_comb begin
      wb_exclude = '0;
      if (pop && head_match) begin
         wb_exclude[head_q] = 1'b1;
      end
   end
`else
   assign wb_exclude = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entries_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

   ysyx_23060203_sb_match #(
      .DEPTH (DEPTH)
   ) u_match_rs1 (
      .entries (entries_q),
      .exclude (wb_exclude),
      .rs      (q_rs1),
      .busy    (rs1_busy)
   );

   ysyx_23060203_sb_match #(
      .DEPTH (DEPTH)
   ) u_match_rs2 (
      .entries (entries_q),
      .exclude (wb_exclude),
      .rs      (q_rs2),
      .busy    (rs2_busy)
   );

   assign hazard = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_ysyx_23060203_scoreboard.sv
module tb_ysyx_23060203_scoreboard;

`ifdef YSYX_23060203_SB_WB_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       issue_fire = 1'b0;
   logic [4:0] issue_rd = '0;
   logic       issue_ready;
   logic [4:0] q_rs1 = '0;
   logic [4:0] q_rs2 = '0;
   logic       rs1_busy, rs2_busy, hazard;
   logic       wb_valid = 1'b0;
   logic [4:0] wb_rd = '0;
   logic [2:0] count;
   logic       empty, full, err;

   always #5 clock = ~clock;

   ysyx_23060203_scoreboard #(
      .DEPTH (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .issue_fire  (issue_fire),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .q_rs1       (q_rs1),
      .q_rs2       (q_rs2),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .hazard      (hazard),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .err         (err)
   );

   // One cycle of stimulus: pre-edge combinational expectations (ready/busy)
   // and post-edge registered expectations (count/err).
   typedef struct {
      string      name;
      logic       fire;
      logic [4:0] rd;
      logic       wb;
      logic [4:0] wrd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       e_rdy;
      logic       e_b1;
      logic       e_b2;
      int         e_cnt;
      logic       e_err;
   } vec_t;

   int total = 0;
   int bad   = 0;
   logic [4:0] model_q[$];

   function automatic vec_t mk(string name, bit fire, int rd, bit wb, int wrd, int rs1,
                               int rs2, bit rdy, bit b1, bit b2, int cnt, bit e);
      vec_t v;
      v.name = name; v.fire = fire; v.rd = 5'(rd); v.wb = wb; v.wrd = 5'(wrd);
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.e_rdy = rdy; v.e_b1 = b1; v.e_b2 = b2;
      v.e_cnt = cnt; v.e_err = e;
      return v;
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step(vec_t v);
      @(negedge clock);
      issue_fire = v.fire; issue_rd = v.rd; wb_valid = v.wb; wb_rd = v.wrd;
      q_rs1 = v.rs1; q_rs2 = v.rs2;
      #1;
      chk({v.name, ".issue_ready"}, int'(issue_ready), int'(v.e_rdy));
      chk({v.name, ".rs1_busy"}, int'(rs1_busy), int'(v.e_b1));
      chk({v.name, ".rs2_busy"}, int'(rs2_busy), int'(v.e_b2));
      chk({v.name, ".hazard"}, int'(hazard), int'(v.e_b1 | v.e_b2));
      @(posedge clock);
      #1;
      if (v.fire && v.e_rdy) model_q.push_back(v.rd);
      if (v.wb && model_q.size() > 0) void'(model_q.pop_front());
      chk({v.name, ".count"}, int'(count), v.e_cnt);
      chk({v.name, ".model_count"}, int'(count), model_q.size());
      chk({v.name, ".full"}, int'(full), int'(v.e_cnt == 4));
      chk({v.name, ".empty"}, int'(empty), int'(v.e_cnt == 0));
      chk({v.name, ".err"}, int'(err), int'(v.e_err));
   endtask

   task automatic do_reset();
      @(negedge clock);
      issue_fire = 1'b0; wb_valid = 1'b0; q_rs1 = '0; q_rs2 = '0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[$];
      //            name        fi rd wb wrd rs1 rs2 rdy b1    b2    cnt err
      tbl.push_back(mk("idle",     0, 0, 0, 0, 0, 0, 1, 0,    0,    0, 0));
      tbl.push_back(mk("iss5",     1, 5, 0, 0, 5, 0, 1, 0,    0,    1, 0));
      tbl.push_back(mk("raw5",     0, 0, 0, 0, 5, 6, 1, 1,    0,    1, 0));
      tbl.push_back(mk("wb5",      0, 0, 1, 5, 5, 0, 1, !Byp, 0,    0, 0));
      tbl.push_back(mk("clr5",     0, 0, 0, 0, 5, 0, 1, 0,    0,    0, 0));
      tbl.push_back(mk("iss0a",    1, 0, 0, 0, 0, 0, 1, 0,    0,    1, 0));
      tbl.push_back(mk("iss0b",    1, 0, 0, 0, 0, 0, 1, 0,    0,    2, 0));
      tbl.push_back(mk("zero_chk", 0, 0, 0, 0, 0, 0, 1, 0,    0,    2, 0));
      tbl.push_back(mk("wb0a",     0, 0, 1, 0, 0, 0, 1, 0,    0,    1, 0));
      tbl.push_back(mk("wb0b",     0, 0, 1, 0, 0, 0, 1, 0,    0,    0, 0));
      tbl.push_back(mk("iss1",     1, 1, 0, 0, 0, 0, 1, 0,    0,    1, 0));
      tbl.push_back(mk("iss2",     1, 2, 0, 0, 0, 1, 1, 0,    1,    2, 0));
      tbl.push_back(mk("iss3",     1, 3, 0, 0, 0, 0, 1, 0,    0,    3, 0));
      tbl.push_back(mk("iss4",     1, 4, 0, 0, 4, 0, 1, 0,    0,    4, 0));
      tbl.push_back(mk("full_hold",0, 0, 0, 0, 4, 3, 0, 1,    1,    4, 0));
      tbl.push_back(mk("wrap",     1, 6, 1, 1, 6, 1, 1, 0,    !Byp, 4, 0));
      tbl.push_back(mk("wrap_chk", 0, 0, 0, 0, 6, 1, 0, 1,    0,    4, 0));
      tbl.push_back(mk("drain2",   0, 0, 1, 2, 0, 0, 1, 0,    0,    3, 0));
      tbl.push_back(mk("drain3",   0, 0, 1, 3, 0, 0, 1, 0,    0,    2, 0));
      tbl.push_back(mk("drain4",   0, 0, 1, 4, 0, 0, 1, 0,    0,    1, 0));
      tbl.push_back(mk("drain6",   0, 0, 1, 6, 6, 0, 1, !Byp, 0,    0, 0));
      tbl.push_back(mk("iss7a",    1, 7, 0, 0, 0, 0, 1, 0,    0,    1, 0));
      tbl.push_back(mk("iss7b",    1, 7, 0, 0, 7, 0, 1, 1,    0,    2, 0));
      tbl.push_back(mk("wb7a",     0, 0, 1, 7, 7, 0, 1, 1,    0,    1, 0));
      tbl.push_back(mk("dup_chk",  0, 0, 0, 0, 7, 0, 1, 1,    0,    1, 0));
      tbl.push_back(mk("wb7b",     0, 0, 1, 7, 7, 0, 1, !Byp, 0,    0, 0));
      tbl.push_back(mk("dup_clr",  0, 0, 0, 0, 7, 0, 1, 0,    0,    0, 0));

      do_reset();
      // Reset state before any stimulus.
      #1;
      chk("reset.count", int'(count), 0);
      chk("reset.empty", int'(empty), 1);
      chk("reset.err", int'(err), 0);
      chk("reset.issue_ready", int'(issue_ready), 1);

      foreach (tbl[i]) step(tbl[i]);

      // Writeback while empty: error, sticky, no pop.
      step(mk("wb_empty",   0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
      step(mk("err_sticky", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

      // Asynchronous reset with three entries in flight.
      step(mk("pre_r1", 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
      step(mk("pre_r2", 1, 2, 0, 0, 0, 0, 1, 0, 0, 2, 1));
      step(mk("pre_r3", 1, 3, 0, 0, 2, 0, 1, 1, 0, 3, 1));
      @(negedge clock);
      issue_fire = 1'b0; wb_valid = 1'b0; q_rs1 = 5'd2; q_rs2 = 5'd3;
      #2 reset = 1'b1;
      #1;
      chk("async_rst.count", int'(count), 0);
      chk("async_rst.empty", int'(empty), 1);
      chk("async_rst.hazard", int'(hazard), 0);
      chk("async_rst.err", int'(err), 0);
      chk("async_rst.issue_ready", int'(issue_ready), 1);
      @(negedge clock);
      reset = 1'b0;
      model_q.delete();

      // Wrong wb_rd: pop still happens, error flagged.
      step(mk("iss3_b",  1, 3, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      step(mk("wb_bad",  0, 0, 1, 9, 3, 0, 1, 1, 0, 0, 1));
      step(mk("post_bad",0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 1));

      // Issue into a full queue without writeback: dropped, error flagged.
      do_reset();
      step(mk("f1", 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      step(mk("f2", 1, 2, 0, 0, 0, 0, 1, 0, 0, 2, 0));
      step(mk("f3", 1, 3, 0, 0, 0, 0, 1, 0, 0, 3, 0));
      step(mk("f4", 1, 4, 0, 0, 0, 0, 1, 0, 0, 4, 0));
      step(mk("overflow",  1, 9, 0, 0, 0, 0, 0, 0, 0, 4, 1));
      step(mk("drop_chk",  0, 0, 0, 0, 9, 1, 0, 0, 1, 4, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_23060203_scoreboard.md
Name: ysyx_23060203_scoreboard

Overview:
- In-order register-hazard scoreboard between the decode stage and writeback.
- Records the rd of every instruction accepted from decode in a DEPTH-entry age-ordered queue; retires the oldest entry on each writeback.
- Compares decode's rs1/rs2 against all in-flight rd values and raises busy/hazard so decode holds out_valid low until the RAW hazard clears.
- Complements the single-stage EXU GPR bypass: covers results still in flight beyond EXU (load/LSU latency).

Parameters:
- DEPTH, 4: maximum in-flight instructions between decode accept and writeback; power of two, ≥2.
- PTR_W, $clog2(DEPTH): queue pointer width; derived, not overridden.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- issue_fire  in  1  decode→EXU handshake completed this cycle (out_valid & out_ready)
- issue_rd  in  5  destination of issuing instruction; 0 = no GPR write
- issue_ready  out  1  queue can accept an issue this cycle; decode ANDs it into out_valid
- q_rs1  in  5  decode's current rs1
- q_rs2  in  5  decode's current rs2
- rs1_busy  out  1  in-flight entry writes q_rs1 (q_rs1≠0)
- rs2_busy  out  1  in-flight entry writes q_rs2 (q_rs2≠0)
- hazard  out  1  rs1_busy | rs2_busy
- wb_valid  in  1  oldest in-flight instruction retires this cycle
- wb_rd  in  5  rd of retiring instruction (must equal head entry rd)
- count  out  PTR_W+1  occupied entries
- empty  out  1  count==0
- full  out  1  count==DEPTH
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, active-high): all entries invalid, head=tail=0, count=0. Outputs: empty=1, full=0, issue_ready=1, rs1_busy=rs2_busy=hazard=0, err=0.
- Storage: circular queue of {valid, rd[4:0]}. Push at tail on issue_fire; pop at head on wb_valid. Pointers wrap modulo DEPTH.
- Every issued instruction pushes, including rd=0 (stores, branches, ecall, fence.i), so push/pop order matches retire order. rd=0 entries never match.
- issue_ready = ~full | wb_valid. Push and pop in the same cycle while full is legal; count is unchanged.
- issue_fire while issue_ready=0: push dropped, err set.
- wb_valid while empty: ignored, err set.
- wb_valid with wb_rd ≠ head rd: pop still occurs, err set.
- err clears only on reset.
- busy logic is combinational from the registered queue. rsX_busy = (q_rsX≠0) & OR over valid entries of (entry.rd==q_rsX). Latency: hazard rises the cycle after the producing issue_fire.
- Simultaneous push and pop in one cycle: both take effect. The pushed entry is visible to busy the next cycle; the popped entry is gone the next cycle.
- Flush: no flush input. Flushed instructions in decode never fired, so the queue is unaffected; EXU and later stages always retire what was issued.

Optional Feature:
- Macro: YSYX_23060203_SB_WB_BYPASS_EN.
- Defined: a valid entry is excluded from the busy match in the cycle it is popped, when wb_valid=1, it is the head, and wb_rd equals the head rd. Decode then reads the writeback value through the register-file write-through path. Hazard drops in the writeback cycle, saving one stall cycle per dependency. A younger matching entry still asserts busy.
- Undefined: busy deasserts only the cycle after the pop.

Decomposition:
- Shared def package (alongside the opcode/csr/alu defines):
  - sb_entry_t struct {valid, rd}
  - SB_DEPTH_DEFAULT constant
- Optional sub-module ysyx_23060203_sb_match: one DEPTH-way rd comparator, instantiated twice (rs1, rs2), parameterised by DEPTH.
- Queue pointers and counters stay in the top module.

Test Plan:
- Reset mid-operation: with count=3, pulse reset → same cycle count=0, empty=1, hazard=0, err=0, issue_ready=1.
- RAW stall: issue rd=5; next cycle q_rs1=5 → rs1_busy=1, hazard=1; wb_valid with wb_rd=5 → hazard=0 the following cycle (without bypass) or the same cycle (with bypass).
- Zero register: issue rd=0 ×2, q_rs1=q_rs2=0 → no busy; count=2; two wb_valid with wb_rd=0 → empty=1.
- Full/wrap: DEPTH=4, issue rd=1,2,3,4 → full=1, issue_ready=0. Same cycle assert wb_valid(rd=1) and issue_fire(rd=6) → count stays 4, tail wraps to 1; q_rs1=6 → busy.
- Younger duplicate: issue rd=7 twice, one wb_valid(rd=7) → rs1_busy (q_rs1=7) stays 1 until the second writeback.
- Protocol errors: wb_valid when empty → err=1 sticky, count stays 0. After reset, issue rd=3 then wb_rd=9 → err=1, count=0.
